alu_arbiter: RTL

Shares one 16-bit ALU among `NREQ` independent requesters. Each requester issues a request with opcode and operands. The block picks a requester round-robin, executes the operation on a single combinational ALU core, and returns a registered result with a zero flag. It sits between the requesting units and the shared ALU datapath and is the only path by which those units reach the ALU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_core.sv | 37 +++
 rtl/alu_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   - OP_* : 3-bit opcode encodings understood by alu_core
//   - state_t : arbiter FSM state encoding (2 bits)
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_SAR   = 3'b100;
    localparam logic [2:0] OP_NAND  = 3'b101;
    localparam logic [2:0] OP_OR    = 3'b110;
    localparam logic [2:0] OP_SHADD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU shared by all requesters.
//   a, b : operands (W bits); b is also the full-width shift amount
//   op   : 3-bit opcode (see alu_pkg)
//   res  : result, modulo 2^W
//   zero : 1 iff res == 0
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] res,
    output logic         zero
);

    always_comb begin
        // NOTE: every output of a combinational block gets a value before the
        // case so that no path leaves it unassigned and infers a latch.
        res = '0;
        unique case (op)
            OP_ADD:   res = a + b;
            OP_SUB:   res = a - b;
            // Shift amounts >= W naturally yield 0 (shl/shr) or all sign bits (sar).
            OP_SHL:   res = a << b;
            OP_SHR:   res = a >> b;
            OP_SAR:   res = W'($signed(a) >>> b);
            OP_NAND:  res = ~(a & b);
            OP_OR:    res = a | b;
            OP_SHADD: res = {b[W-2:0], 1'b0} + a;
        endcase
    end

    assign zero = (res == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting NREQ requesters access to one shared alu_core.
//   clk, reset      : clock, synchronous active-high reset
//   req             : per-requester level request
//   op_in/a_in/b_in : packed per-requester opcode and operands
//   gnt             : one-cycle one-hot pulse, operands of that requester latched
//   done            : one-cycle one-hot pulse, out/zerof valid for that requester
//   out, zerof      : registered result and zero flag, held between operations
//   busy            : FSM not in IDLE
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] op_in,
    input  logic [W*NREQ-1:0] a_in,
    input  logic [W*NREQ-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      out,
    output logic              zerof,
    output logic              busy
);

    localparam int IDW = $clog2(NREQ);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic           any_req;

    logic [2:0]     op_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [W-1:0]   res;
    logic           res_zero;

    // Unpacked views of the packed request buses for clean indexing by win.
    logic [2:0]     op_arr [NREQ];
    logic [W-1:0]   a_arr  [NREQ];
    logic [W-1:0]   b_arr  [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign op_arr[i] = op_in[3*i +: 3];
        assign a_arr[i]  = a_in[W*i +: W];
        assign b_arr[i]  = b_in[W*i +: W];
    end

    // Search from ptr upward with wrap-around. Walking the offsets downward
    // lets the nearest requester overwrite any farther one.
    always_comb begin
        any_req = 1'b0;
        win     = ptr;
        cand    = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                any_req = 1'b1;
                win     = cand;
            end
        end
    end

    alu_core #(.W(W)) u_core (
        .a    (a_r),
        .b    (b_r),
        .op   (op_r),
        .res  (res),
        .zero (res_zero)
    );

    // NOTE: operand registers are always loaded before they are read, so they
    // carry no reset; keeping them out of the reset block avoids a needless
    // reset-driven enable on the datapath.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && any_req) begin
            op_r <= op_arr[win];
            a_r  <= a_arr[win];
            b_r  <= b_arr[win];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= ST_IDLE;
            ptr   <= '0;
            id    <= '0;
            gnt   <= '0;
            done  <= '0;
            out   <= '0;
            zerof <= 1'b0;
        end else begin
            gnt  <= '0;
            done <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        id       <= win;
                        gnt[win] <= 1'b1;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    out      <= res;
                    zerof    <= res_zero;
                    done[id] <= 1'b1;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    ptr   <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
